// File: rtl/image_loader_if.sv
// Load-request and memory-read signals of the image loader.
// The slave modport is the loader's view; master is the requester/memory side.
interface image_loader_if #(
   parameter int DATA_SZ = 16,
   parameter int ADDR_SZ = 16
);
   logic                      loadEnable;
   logic [ADDR_SZ-1:0]        loadAddr;
   logic [DATA_SZ-1:0]        loadSize;
   logic                      loadDone;
   logic                      sizeErr;
   logic [ADDR_SZ-1:0]        memAddr;
   logic                      memRdEn;
   logic signed [DATA_SZ-1:0] memData;

   modport slave (
      input  loadEnable, loadAddr, loadSize, memData,
      output loadDone, sizeErr, memAddr, memRdEn
   );

   modport master (
      output loadEnable, loadAddr, loadSize, memData,
      input  loadDone, sizeErr, memAddr, memRdEn
   );
endinterface

// File: rtl/image_loader.sv
// Streams an N*N image from memory into a row-major buffer, one read per cycle.
// Define LOADER_ZERO_FILL_EN to clear the whole buffer when each load starts.
module image_loader #(
   parameter int DATA_SZ   = 16,
   parameter int ADDR_SZ   = 16,
   parameter int BUF_DEPTH = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   image_loader_if.slave             bus,
   output logic signed [DATA_SZ-1:0] loadOut [BUF_DEPTH]
);
   localparam int PROD_W = 2 * DATA_SZ;
   localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
   localparam int IDX_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [ADDR_SZ-1:0] base_r, base_s;
   logic [CNT_W-1:0]   count_r, count_s;
   logic [CNT_W-1:0]   rd_idx_r, rd_idx_s;
   logic [ADDR_SZ-1:0] mem_addr_r, mem_addr_s;
   logic               mem_rd_en_r, mem_rd_en_s;
   logic               load_done_r, load_done_s;
   logic               size_err_r, size_err_s;
   logic               cap_valid_r;
   logic [IDX_W-1:0]   cap_idx_r;

   logic [PROD_W-1:0]  product_s;
   logic               over_s;
   logic [CNT_W-1:0]   clamp_s;

   assign product_s = PROD_W'(bus.loadSize) * PROD_W'(bus.loadSize);
   assign over_s    = (product_s > PROD_W'(BUF_DEPTH));
   assign clamp_s   = over_s ? CNT_W'(BUF_DEPTH) : CNT_W'(product_s);

   assign bus.memAddr  = mem_addr_r;
   assign bus.memRdEn  = mem_rd_en_r;
   assign bus.loadDone = load_done_r;
   assign bus.sizeErr  = size_err_r;

   // Next-state and next-output logic
   always_comb begin
      state_s     = state_r;
      base_s      = base_r;
      count_s     = count_r;
      rd_idx_s    = rd_idx_r;
      mem_addr_s  = mem_addr_r;
      mem_rd_en_s = 1'b0;
      load_done_s = 1'b0;
      size_err_s  = size_err_r;
      case (state_r)
         IDLE: begin
            if (bus.loadEnable) begin
               base_s     = bus.loadAddr;
               count_s    = clamp_s;
               size_err_s = over_s;
               if (clamp_s == CNT_W'(0)) begin
                  state_s     = DONE;
                  load_done_s = 1'b1;
               end else begin
                  // Read 0 is issued on the latch edge itself
                  state_s     = READ;
                  mem_rd_en_s = 1'b1;
                  mem_addr_s  = bus.loadAddr;
                  rd_idx_s    = CNT_W'(1);
               end
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            if (rd_idx_r == count_r) begin
               state_s = DRAIN;
            end else begin
               mem_rd_en_s = 1'b1;
               mem_addr_s  = base_r + ADDR_SZ'(rd_idx_r);
               rd_idx_s    = rd_idx_r + CNT_W'(1);
            end
         end
         DRAIN: begin
            state_s     = DONE;
            load_done_s = 1'b1;
         end
         DONE: begin
            if (bus.loadEnable) begin
               load_done_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, registered outputs and capture pipeline
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= IDLE;
         base_r      <= '0;
         count_r     <= '0;
         rd_idx_r    <= '0;
         mem_addr_r  <= '0;
         mem_rd_en_r <= 1'b0;
         load_done_r <= 1'b0;
         size_err_r  <= 1'b0;
         cap_valid_r <= 1'b0;
         cap_idx_r   <= '0;
      end else begin
         state_r     <= state_s;
         base_r      <= base_s;
         count_r     <= count_s;
         rd_idx_r    <= rd_idx_s;
         mem_addr_r  <= mem_addr_s;
         mem_rd_en_r <= mem_rd_en_s;
         load_done_r <= load_done_s;
         size_err_r  <= size_err_s;
         // memData answers the strobe of the previous cycle
         cap_valid_r <= mem_rd_en_r;
         cap_idx_r   <= IDX_W'(rd_idx_r - CNT_W'(1));
      end
   end

`ifdef LOADER_ZERO_FILL_EN
   logic start_s;
   assign start_s = (state_r == IDLE) && bus.loadEnable;
`endif

   // Image buffer: no reset, written only by captures (and the optional clear)
   always_ff @(posedge clk) begin
      if (!reset) begin
         // an aborted load leaves the buffer as it was
      end
`ifdef LOADER_ZERO_FILL_EN
      else if (start_s) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            loadOut[i] <= '0;
         end
      end
`endif
      else if (cap_valid_r) begin
         loadOut[cap_idx_r] <= bus.memData;
      end
   end
endmodule

// File: tb/tb_image_loader.sv
// Randomized bench for image_loader against a transaction-level buffer model.
module tb_image_loader;
   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic reset;
   logic signed [DW-1:0] load_out [DEPTH];

   image_loader_if #(.DATA_SZ(DW), .ADDR_SZ(AW)) bus ();

   image_loader #(.DATA_SZ(DW), .ADDR_SZ(AW), .BUF_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .loadOut (load_out)
   );

   always #5 clk = ~clk;

   logic signed [DW-1:0] mem     [65536];
   logic signed [DW-1:0] ref_buf [DEPTH];
   bit                   ref_known [DEPTH];
   logic [AW-1:0]        rd_q [$];
   int                   n_checks = 0;
   int                   n_pass   = 0;
   int                   exp_n;
   bit                   exp_err;

   // Memory: data one cycle after the strobe, noise otherwise
   always @(posedge clk) begin
      if (bus.memRdEn === 1'b1) bus.memData <= mem[bus.memAddr];
      else                      bus.memData <= 16'($urandom);
   end

   // Record every issued read address
   always @(negedge clk) begin
      if (bus.memRdEn === 1'b1) rd_q.push_back(bus.memAddr);
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Model of one load: words at base+k (mod 2^16) land in entry k
   function automatic void ref_load(input logic [AW-1:0] addr, input int size, input int upto);
      int n;
      logic [AW-1:0] a;
      n = size * size;
      if (n > DEPTH) n = DEPTH;
`ifdef LOADER_ZERO_FILL_EN
      for (int k = 0; k < DEPTH; k++) begin
         ref_buf[k]   = '0;
         ref_known[k] = 1'b1;
      end
`endif
      for (int k = 0; k < n && k < upto; k++) begin
         a = addr + AW'(k);
         ref_buf[k]   = mem[a];
         ref_known[k] = 1'b1;
      end
   endfunction

   task automatic compare_buf(input string tag);
      int bad = 0;
      int first = -1;
      for (int k = 0; k < DEPTH; k++) begin
         if (ref_known[k] && load_out[k] !== ref_buf[k]) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      check_eq(tag, bad, 0);
      if (bad != 0) $display("  first differing entry %0d", first);
   endtask

   task automatic issue(input logic [AW-1:0] addr, input int size);
      @(negedge clk);
      reset          = 1'b1;
      bus.loadEnable = 1'b1;
      bus.loadAddr   = addr;
      bus.loadSize   = 16'(size);
      rd_q.delete();
      exp_n   = size * size;
      exp_err = (exp_n > DEPTH);
      if (exp_err) exp_n = DEPTH;
      @(posedge clk);
      #1;
      // later changes must not disturb the load
      bus.loadAddr = 16'($urandom);
      bus.loadSize = 16'($urandom_range(0, 64));
   endtask

   task automatic finish_load(input logic [AW-1:0] addr, input int size, input string tag);
      int cyc = 0;
      int bad = 0;
      int lat;
      lat = (exp_n == 0) ? 1 : exp_n + 2;
      while (cyc < lat + 20) begin
         @(negedge clk);
         cyc++;
         if (bus.loadDone === 1'b1) break;
      end
      check_eq({tag, ".latency"}, cyc, lat);
      check_eq({tag, ".size_err"}, bus.sizeErr, exp_err);
      check_eq({tag, ".reads"}, rd_q.size(), exp_n);
      for (int k = 0; k < rd_q.size(); k++) begin
         if (rd_q[k] !== addr + AW'(k)) bad++;
      end
      check_eq({tag, ".addr_seq"}, bad, 0);
      ref_load(addr, size, size * size);
      compare_buf({tag, ".buf"});
      @(negedge clk);
      check_eq({tag, ".done_hold"}, {bus.loadDone, bus.memRdEn}, 2'b10);
      bus.loadEnable = 1'b0;
      @(negedge clk);
      check_eq({tag, ".done_drop"}, bus.loadDone, 1'b0);
      check_eq({tag, ".err_sticky"}, bus.sizeErr, exp_err);
      compare_buf({tag, ".idle_stable"});
   endtask

   initial begin
      logic [AW-1:0]        a;
      logic [AW-1:0]        abort_base;
      logic signed [DW-1:0] old_v [9];
      int                   sz;
      int                   w;

      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'(16'h0100 + i);
      for (int k = 0; k < DEPTH; k++) ref_known[k] = 1'b0;

      reset          = 1'b0;
      bus.loadEnable = 1'b0;
      bus.loadAddr   = 16'h0000;
      bus.loadSize   = 16'h0000;
      repeat (3) @(negedge clk);
      check_eq("reset.outputs", {bus.memRdEn, bus.loadDone, bus.sizeErr}, 3'b000);
      check_eq("reset.addr", bus.memAddr, 16'h0000);

      // 4x4 image where memory[a] = a
      issue(16'h0100, 4);
      finish_load(16'h0100, 4, "l4x4");
      check_eq("l4x4.first_addr", rd_q[0], 16'h0100);
      check_eq("l4x4.last_word", load_out[15], 16'h010F);

      issue(16'h1234, 0);
      finish_load(16'h1234, 0, "empty");

      // Address wrap at the top of memory
      issue(16'hFFFE, 2);
      finish_load(16'hFFFE, 2, "wrap");
      check_eq("wrap.addr2", rd_q[2], 16'h0000);
      check_eq("wrap.addr3", rd_q[3], 16'h0001);

      // 3x3 followed by 2x2: entries 4..8 either survive or are cleared
      a = 16'($urandom);
      issue(a, 3);
      finish_load(a, 3, "l3x3");
      for (int k = 4; k < 9; k++) old_v[k] = ref_buf[k];
      a = 16'($urandom);
      issue(a, 2);
      finish_load(a, 2, "l2x2");
      for (int k = 4; k < 9; k++) begin
`ifdef LOADER_ZERO_FILL_EN
         check_eq($sformatf("reuse.entry%0d", k), load_out[k], 16'sd0);
`else
         check_eq($sformatf("reuse.entry%0d", k), load_out[k], old_v[k]);
`endif
      end

      issue(16'h3000, 40);
      finish_load(16'h3000, 40, "oversize");

      // Reset while read 5 of a 3x3 load is on the bus
      abort_base = 16'($urandom);
      issue(abort_base, 3);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (w < 30 && !(bus.memRdEn === 1'b1 && bus.memAddr === abort_base + 16'd5));
      check_eq("abort.read5_cycle", w, 6);
      reset = 1'b0;
      @(negedge clk);
      check_eq("abort.outputs", {bus.memRdEn, bus.loadDone, bus.sizeErr}, 3'b000);
      check_eq("abort.addr", bus.memAddr, 16'h0000);
      ref_load(abort_base, 3, 4);
      compare_buf("abort.buf");
      @(negedge clk);
      compare_buf("abort.buf_hold");
      // loadEnable is still high: releasing reset starts a fresh load
      a = 16'($urandom);
      issue(a, 3);
      finish_load(a, 3, "restart");

      for (int t = 0; t < 6; t++) begin
         a  = 16'($urandom);
         sz = ($urandom_range(0, 4) == 0) ? 33 : $urandom_range(0, 12);
         issue(a, sz);
         finish_load(a, sz, $sformatf("rand%0d", t));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
- REQ-001: Parameter DATA_SZ, default 16, word width of memory data and buffer entries.
- REQ-002: Parameter ADDR_SZ, default 16, memory address width.
- REQ-003: Parameter BUF_DEPTH, default 1024, buffer entry count (max image 32x32).
- REQ-004: clk  input  1  single clock; all logic SHALL update on its rising edge.
- REQ-005: reset  input  1  synchronous, active-low reset; asserted when low, sampled only on the rising edge of clk.
- REQ-006: loadEnable  input  1  load request from the consuming layer.
- REQ-007: loadAddr  input  ADDR_SZ  base memory address of the image.
- REQ-008: loadSize  input  DATA_SZ  image side length N; the image holds N*N words.
- REQ-009: memAddr  output  ADDR_SZ  memory read address.
- REQ-010: memRdEn  output  1  memory read strobe.
- REQ-011: memData  input  signed DATA_SZ  read data, valid exactly one cycle after memRdEn.
- REQ-012: loadOut  output  signed DATA_SZ x BUF_DEPTH  unpacked image buffer, row-major, index 0 = loadAddr.
- REQ-013: loadDone  output  1  load-complete level.
- REQ-014: sizeErr  output  1  sticky flag: last request exceeded BUF_DEPTH.

Function
- REQ-015: The FSM SHALL have four states: IDLE, READ, DRAIN and DONE.
- REQ-016: IDLE with loadEnable=1 SHALL latch loadAddr, compute count=loadSize*loadSize at 2*DATA_SZ width, and enter READ.
- REQ-017: If count>BUF_DEPTH, the loader SHALL clamp count to BUF_DEPTH and set sizeErr; otherwise it SHALL clear sizeErr at latch time.
- REQ-018: If count=0, the loader SHALL go IDLE->DONE directly with no memRdEn pulse.
- REQ-019: READ SHALL issue one read per cycle: memRdEn=1, memAddr=base+k for k=0..count-1, with the address wrapping modulo 2^ADDR_SZ.
- REQ-020: The memData returned for read k SHALL be written into loadOut[k] on the following edge.
- REQ-021: After read count-1 is issued, the FSM SHALL go to DRAIN with memRdEn=0; DRAIN captures the last word and goes to DONE.
- REQ-022: Load latency SHALL be count+2 cycles from the request edge to loadDone=1.
- REQ-023: In DONE, loadDone SHALL be 1 and held while loadEnable=1.
- REQ-024: In DONE, loadEnable=0 SHALL return the FSM to IDLE with loadDone=0 on the next edge.
- REQ-025: A new load SHALL start only from IDLE; the loader SHALL ignore loadEnable in READ and DRAIN.
- REQ-026: Changes on loadAddr or loadSize after latch SHALL have no effect on the load in progress.
- REQ-027: loadOut entries at index >= count SHALL keep their prior contents, unless overridden by REQ-033.
- REQ-028: loadOut SHALL be stable in DONE and IDLE.

Reset
- REQ-029: When reset=0 at an edge, the FSM SHALL enter IDLE with memRdEn=0, memAddr=0, loadDone=0 and sizeErr=0.
- REQ-030: Reset mid-load SHALL abort immediately with no further buffer writes; loadOut is not reset and stays undefined until the first load.
- REQ-031: After reset deasserts, a loadEnable still held at 1 SHALL start a fresh load.

Configuration
- REQ-032: Macro LOADER_ZERO_FILL_EN SHALL compile the zero-fill feature in or out.
- REQ-033: With LOADER_ZERO_FILL_EN defined, on the IDLE->READ or IDLE->DONE transition all loadOut entries SHALL be set to 0 in that same edge, before any capture.
- REQ-034: Without LOADER_ZERO_FILL_EN, REQ-027 applies unchanged and no clear logic SHALL be synthesized.

Verification
- REQ-035: loadAddr=0x0100, loadSize=4, memory[a]=a -> memRdEn high 16 cycles at 0x0100..0x010F; loadOut[0..15]=0x0100..0x010F; loadDone at cycle 18.
- REQ-036: loadSize=0 -> no memRdEn; loadDone=1 one cycle after request; loadDone drops the cycle after loadEnable=0.
- REQ-037: loadSize=40 -> sizeErr=1; exactly 1024 reads issued; loadDone after 1026 cycles.
- REQ-038: loadAddr=0xFFFE, loadSize=2 -> memAddr sequence FFFE, FFFF, 0000, 0001.
- REQ-039: Reset=0 at read 5 of a 3x3 load -> next cycle memRdEn=0, loadDone=0; loadOut[5..8] unchanged.
- REQ-040: 3x3 load, then 2x2 load -> loadOut[4..8] equals the old data without the macro and 0 with LOADER_ZERO_FILL_EN.
